truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequential characterizer for 3-input combinational gate modules, the read-back counterpart of a truth-table gate.
- Drives all eight input combinations into a device under test (DUT), waits a settle interval and samples the DUT output.
- Assembles the 8-bit truth-table code, compares it against an expected code and reports through a start/done handshake.
- Used in benches and self-test wrappers to confirm that a gate netlist realises its named hex function.

Parameters:
- SETTLE_CYCLES, 4: clock cycles each input row is held before the first sample; legal range 1..255.
- STABLE_CHECK, 1: when 1, the output is sampled on two consecutive cycles and a mismatch between them sets glitch; when 0, a single sample is taken.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; honoured only in IDLE.
- exp_table  input  8  expected truth-table code; captured on an accepted start.
- dut_in  output  3  drives {in1,in2,in3} of the DUT; dut_in[2]=in1 (MSB), dut_in[0]=in3.
- dut_out  input  1  DUT output.
- busy  output  1  high from the cycle after an accepted start until done asserts.
- done  output  1  one-cycle pulse when the sweep completes.
- table_out  output  8  measured truth-table code; held until the next accepted start.
- match  output  1  table_out == captured exp_table; valid from done until the next start.
- glitch  output  1  sticky for the current sweep: some row's two samples disagreed.

Behaviour:
- Reset values: dut_in=0, busy=0, done=0, table_out=0, match=0, glitch=0; FSM in IDLE; row counter=0; settle counter=0.
- Bit mapping: row r = {in1,in2,in3} as an unsigned value 0..7; table_out[7-r] = sampled output for row r. A 3-input AND therefore yields 0x01, and OR yields 0x7F.
- FSM states: IDLE, SETTLE, SAMPLE, CHECK, FINISH.
- IDLE: dut_in=0. On start=1:
  - capture exp_table; clear table_out, match and glitch;
  - set row=0, settle counter=SETTLE_CYCLES-1;
  - go to SETTLE.
  - start while busy is ignored.
- SETTLE: dut_in=row. Decrement the settle counter each cycle; on the cycle it reads 0, go to SAMPLE. Each row therefore spends exactly SETTLE_CYCLES cycles in SETTLE.
- SAMPLE: dut_in=row; register dut_out as sample A.
  - STABLE_CHECK=1: go to CHECK.
  - STABLE_CHECK=0: write A into table_out[7-row], then advance.
- CHECK: dut_in=row; register dut_out as sample B.
  - Write B into table_out[7-row].
  - If A != B, set glitch to 1 (sticky until the next start).
  - Advance.
- Advance:
  - If row==7, go to FINISH.
  - Otherwise row increments by 1 (3-bit, no wrap reached), the settle counter reloads to SETTLE_CYCLES-1, and the FSM goes to SETTLE.
- FINISH: one cycle. done=1, busy=0, match=(table_out==exp_captured). Return to IDLE, where dut_in returns to 0 on the following cycle.
- Latency from the start cycle to the done pulse: 8*(SETTLE_CYCLES+1+STABLE_CHECK)+1 cycles. With defaults this is 49.
- busy is high in SETTLE, SAMPLE and CHECK; it is low in IDLE and FINISH.
- start in the same cycle as the done pulse is ignored, because the FSM is not yet in IDLE. start on the next cycle is accepted.
- rst asserted mid-sweep returns every output to its reset value on the next edge. No done pulse is produced, and a partial table_out is discarded.
- exp_table changes during a sweep have no effect.

Test Plan:
- AND DUT (out=in1&in2&in3), exp_table=0x01, defaults -> done pulses 49 cycles after start; table_out=0x01, match=1, glitch=0.
- OR DUT, exp_table=0x01 -> table_out=0x7F, match=0, glitch=0; dut_in visits rows 0..7 in order, each held 6 cycles.
- XOR3 DUT, SETTLE_CYCLES=1, STABLE_CHECK=0 -> done after 17 cycles; table_out=0x69 (rows 1,2,4,7 high, i.e. bits 6,5,3,0 set).
- DUT output forced to toggle every cycle during row 3, otherwise AND -> glitch=1 at done; table_out bit 4 equals sample B; glitch clears on the next start.
- rst pulsed at cycle 20 of a sweep -> next cycle busy=0, dut_in=0, table_out=0; no done pulse; a fresh start then completes normally.
- start re-pulsed while busy, and again in the done cycle -> both ignored (single done); start one cycle after done launches a new sweep.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all eight rows into a 3-input gate,
// samples its output and assembles/compares the 8-bit truth-table code.
module truth_table_sweeper #(
    parameter int SETTLE_CYCLES = 4,
    parameter int STABLE_CHECK  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] exp_table,
    output logic [2:0] dut_in,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       match,
    output logic       glitch
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETTLE = 3'd1;
    localparam logic [2:0] SAMPLE = 3'd2;
    localparam logic [2:0] CHECK  = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    logic [2:0] state;
    logic [2:0] row;
    logic [7:0] settle_cnt;
    logic [7:0] exp_q;
    logic       sample_a;
    logic       match_q;

    // Sweep sequencer: settle, sample (twice when stable-checking), advance row
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row        <= 3'd0;
            settle_cnt <= 8'd0;
            exp_q      <= 8'd0;
            sample_a   <= 1'b0;
            table_out  <= 8'd0;
            glitch     <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        exp_q      <= exp_table;
                        table_out  <= 8'd0;
                        match_q    <= 1'b0;
                        glitch     <= 1'b0;
                        row        <= 3'd0;
                        settle_cnt <= RELOAD;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 8'd0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                SAMPLE: begin
                    sample_a <= dut_out;
                    if (STABLE_CHECK != 0) begin
                        state <= CHECK;
                    end else begin
                        table_out[3'd7 - row] <= dut_out;
                        if (row == 3'd7) begin
                            state <= FINISH;
                        end else begin
                            row        <= row + 3'd1;
                            settle_cnt <= RELOAD;
                            state      <= SETTLE;
                        end
                    end
                end
                CHECK: begin
                    table_out[3'd7 - row] <= dut_out;
                    if (sample_a != dut_out) begin
                        glitch <= 1'b1;
                    end
                    if (row == 3'd7) begin
                        state <= FINISH;
                    end else begin
                        row        <= row + 3'd1;
                        settle_cnt <= RELOAD;
                        state      <= SETTLE;
                    end
                end
                FINISH: begin
                    match_q <= (table_out == exp_q);
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Row drive and status decoded from the sequencer state
    always_comb begin
        dut_in = (state == IDLE) ? 3'd0 : row;
        busy   = (state == SETTLE) || (state == SAMPLE) || (state == CHECK);
        done   = (state == FINISH);
        match  = (state == FINISH) ? (table_out == exp_q) : match_q;
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: scoreboard bench for the truth-table sweeper,
// using behavioural AND/OR/XOR3 gates and a glitching gate as DUTs.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] exp_table = 8'd0;
    logic [2:0] dut_in;
    logic       dut_out;
    logic       busy, done, match, glitch;
    logic [7:0] table_out;

    logic       f_start = 1'b0;
    logic [7:0] f_exp = 8'd0;
    logic [2:0] f_in;
    logic       f_out;
    logic       f_busy, f_done, f_match, f_glitch;
    logic [7:0] f_table;

    int   mode = 0;
    logic tog = 1'b0;
    logic last_b = 1'b0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic [7:0] tbl;
        logic [7:0] exp;
        logic       g;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    truth_table_sweeper u_dut (
        .clk(clk), .rst(rst), .start(start), .exp_table(exp_table),
        .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
        .table_out(table_out), .match(match), .glitch(glitch)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1), .STABLE_CHECK(0)) u_fast (
        .clk(clk), .rst(rst), .start(f_start), .exp_table(f_exp),
        .dut_in(f_in), .dut_out(f_out), .busy(f_busy), .done(f_done),
        .table_out(f_table), .match(f_match), .glitch(f_glitch)
    );

    // Gate models; mode 2 is AND with row 3 toggling every cycle
    always_comb begin
        case (mode)
            1:       dut_out = |dut_in;
            2:       dut_out = (dut_in == 3'd3) ? tog : &dut_in;
            default: dut_out = &dut_in;
        endcase
        f_out = ^f_in;
    end

    always @(posedge clk) tog <= ~tog;

    // Value the DUT sees at the next edge while row 3 is driven
    always @(negedge clk) if (dut_in == 3'd3) last_b = tog;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({dut_in, busy, done, table_out, match, glitch} !== 15'd0) begin
            bad++;
            $display("FAIL reset: got in=%0d busy=%b done=%b tbl=%h m=%b g=%b want all 0",
                     dut_in, busy, done, table_out, match, glitch);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic sweep(input logic [7:0] exp, input logic [7:0] want,
                         input logic wg, input bit repulse,
                         input bit done_start, input string nm);
        exp_t e;
        int n;
        int row_err;
        logic [7:0] wt;
        e.tbl = want; e.exp = exp; e.g = wg;
        sb.push_back(e);
        exp_table = exp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_table = ~exp;
        total++;
        if ({table_out, match, glitch} !== 10'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_clear: got tbl=%h m=%b g=%b busy=%b want 00 0 0 1",
                     nm, table_out, match, glitch, busy);
        end
        n = 1;
        row_err = 0;
        while (done !== 1'b1 && n < 200) begin
            if (dut_in !== 3'((n - 1) / 6) || busy !== 1'b1) row_err++;
            start = (repulse && n == 10) ? 1'b1 : 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        total++;
        if (row_err != 0) begin
            bad++;
            $display("FAIL %s_rows: got %0d bad row/busy cycles want 0", nm, row_err);
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: got no done want done at 49", nm);
            void'(sb.pop_front());
            return;
        end
        if (n != 49) begin
            bad++;
            $display("FAIL %s_latency: got %0d want 49", nm, n);
        end
        e = sb.pop_front();
        wt = e.tbl;
        if (mode == 2) wt[4] = last_b;
        total++;
        if (table_out !== wt || match !== (wt == e.exp) || glitch !== e.g) begin
            bad++;
            $display("FAIL %s_result: got tbl=%h m=%b g=%b want tbl=%h m=%b g=%b",
                     nm, table_out, match, glitch, wt, (wt == e.exp), e.g);
        end
        if (done_start) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || table_out !== wt || match !== (wt == e.exp)) begin
            bad++;
            $display("FAIL %s_after: got done=%b busy=%b tbl=%h m=%b want 0 0 %h %b",
                     nm, done, busy, table_out, match, wt, (wt == e.exp));
        end
    endtask

    task automatic test_and();
        mode = 0;
        sweep(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, "and");
    endtask

    task automatic test_or();
        mode = 1;
        sweep(8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, "or");
    endtask

    task automatic test_xor_fast();
        exp_t e;
        int n;
        e.tbl = 8'h69; e.exp = 8'h69; e.g = 1'b0;
        sb.push_back(e);
        f_exp = 8'h69;
        f_start = 1'b1;
        @(negedge clk);
        f_start = 1'b0;
        f_exp = 8'h00;
        n = 1;
        while (f_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        total++;
        if (f_done !== 1'b1 || n != 17) begin
            bad++;
            $display("FAIL xor_latency: got %0d done=%b want 17", n, f_done);
        end
        total++;
        if (f_table !== e.tbl || f_match !== 1'b1 || f_glitch !== e.g) begin
            bad++;
            $display("FAIL xor_result: got tbl=%h m=%b g=%b want %h 1 0",
                     f_table, f_match, f_glitch, e.tbl);
        end
        @(negedge clk);
    endtask

    task automatic test_glitch();
        mode = 2;
        sweep(8'h01, 8'h01, 1'b1, 1'b0, 1'b0, "glitch");
        mode = 0;
        sweep(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, "glitch_clear");
    endtask

    task automatic test_mid_reset();
        int dones;
        mode = 1;
        exp_table = 8'h7F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({dut_in, busy, done, table_out, match, glitch} !== 15'd0) begin
            bad++;
            $display("FAIL midrst: got in=%0d busy=%b done=%b tbl=%h m=%b g=%b want all 0",
                     dut_in, busy, done, table_out, match, glitch);
        end
        dones = 0;
        repeat (60) begin
            if (done === 1'b1 || busy === 1'b1) dones++;
            @(negedge clk);
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL midrst_idle: got %0d busy/done cycles want 0", dones);
        end
        sweep(8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0, "midrst_fresh");
    endtask

    task automatic test_back_to_back();
        mode = 0;
        sweep(8'hFF, 8'h01, 1'b0, 1'b1, 1'b1, "b2b_first");
        mode = 1;
        sweep(8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_and();
        test_or();
        test_xor_fast();
        test_glitch();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
